cache_fill_fsm: RTL
===================

# cache_fill_fsm

Cache-side responder for block fills: accepts a miss from the I/D miss arbiter, fetches the 8-word block from multicycle main memory, and drives the cache array write enables. Its `fsm_busy`, `write_data_array` and `write_tag_array` outputs feed the arbiter that selects which cache owns the fill. `miss_address` comes from that arbiter. `memory_data` goes straight from memory to the cache.

## Interface
- `BLOCK_WORDS`, 8: 16-bit words per cache block, i.e. 16 bytes.
- `ADDR_W`, 16: byte-address width.
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `miss_detected`  in  1  an I- or D-cache miss is pending.
- `miss_address`  in  16  byte address that missed; any alignment.
- `memory_data_valid`  in  1  memory returns one word this cycle.
- `fsm_busy`  out  1  fill in progress.
- `mem_read`  out  1  issue a read request to memory this cycle.
- `memory_address`  out  16  byte address of the current read request.
- `write_data_array`  out  1  write the returned word into the cache data array.
- `fill_word`  out  3  word index within the block for `write_data_array`.
- `write_tag_array`  out  1  write the tag and set valid; pulses with the last data write.

## Operation
- **States:** IDLE, FILL.
- **Registers:**
  - `base`: block address, `miss_address & 16'hFFF0`.
  - `req_cnt`: 4 bits, 0..8, counts issued requests.
  - `rsp_cnt`: 4 bits, 0..8, counts accepted returns.
- **IDLE:**
  - Outputs low.
  - `memory_address = miss_address & 16'hFFF0`.
  - When `miss_detected=1`: latch `base`, clear both counters, go to FILL.
- **FILL, request side:**
  - `mem_read = (req_cnt < 8)`.
  - `memory_address = base + {req_cnt[2:0],1'b0}`.
  - `req_cnt` increments on each cycle `mem_read=1`.
- **FILL, return side:**
  - `write_data_array = memory_data_valid`.
  - `fill_word = rsp_cnt[2:0]`.
  - `rsp_cnt` increments on each valid.
  - Returns are in request order; the FSM counts pulses and assumes no fixed latency.
- **Completion:**
  - When `memory_data_valid & rsp_cnt==7`: `write_tag_array=1` in the same cycle, next state IDLE.
- **Busy signal:** `fsm_busy = (state==FILL)`, decoded from registered state.
- **Ignored inputs:**
  - `miss_detected` while in FILL, including any `miss_address` change; `base` stays frozen.
  - `memory_data_valid` in IDLE: no write, no count.
- **Back-to-back fills:** `miss_detected=1` in the first IDLE cycle after a fill starts a new fill immediately.
- **Reset:**
  - Outputs during reset: all outputs 0; `memory_address` = aligned `miss_address`.
  - Post-reset state: IDLE, counters 0.
  - Reset mid-FILL aborts the fill with no tag write. Late memory returns then arrive in IDLE and are ignored.
- **Address arithmetic:** 16-bit, no carry out. The block is aligned, so offsets 0..14 never wrap.

## Timing
- Cycle 0 (IDLE): `miss_detected` sampled high.
- Cycles 1..8: `mem_read=1`, addresses `base+0` through `base+14`.
- With the standard 4-cycle memory:
  - Valid arrives cycles 5..12.
  - Word k is written in cycle 5+k.
  - `write_tag_array` pulses in cycle 12.
- Cycle 13: `fsm_busy=0`.
- Busy window: 12 cycles per fill.
- Minimum miss-to-tag latency: 12 cycles.
- Gaps in `memory_data_valid` stretch FILL with no loss of words.
- `rsp_cnt` never exceeds `req_cnt`; a valid with `rsp_cnt==req_cnt` is a protocol error and is flagged by bench assertion.

## Structure
- Shared package holds:
  - `BLOCK_WORDS` and the offset mask `16'hFFF0`.
  - State encoding: IDLE=1'b0, FILL=1'b1.
- Sub-module `fill_counter`: 4-bit synchronous counter with `clr`, `inc` and synchronous active-high `rst`. Instantiated twice, for requests and returns.
- Remaining logic: next-state and output decode at top level.

## Test plan
- **Basic fill:** `miss_address=16'h1234`, 4-cycle memory.
  - Requests to 0x1230..0x123E in cycles 1..8.
  - Writes with `fill_word` 0..7 in cycles 5..12.
  - `write_tag_array` in cycle 12 only; `fsm_busy` low at cycle 13.
- **Stalled memory:** insert 2-cycle gaps between valids.
  - Exactly 8 data writes, in word order.
  - Tag write coincides with the 8th; `fsm_busy` holds until then.
- **Miss during fill:** `miss_detected` held high and `miss_address` changed to 0x5678 mid-fill.
  - No change to `base`.
  - New fill for 0x5670 starts at cycle 13; cycle-13 `memory_address=0x5670`.
- **Spurious return:** `memory_data_valid` pulsed in IDLE → no `write_data_array`, no state change.
- **Reset mid-fill:** `rst` high at cycle 7.
  - Next cycle all outputs 0, state IDLE.
  - Remaining returns cause no writes; no `write_tag_array` ever.
- **Top-of-memory block:** `miss_address=16'hFFFF` → addresses 0xFFF0..0xFFFE, no wrap past 0xFFFE.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache block-fill responder: block geometry,
// address masking, counter sizing and the fill FSM state encoding.
package cache_fill_fsm_pkg;

  localparam int BLOCK_WORDS = 8;
  localparam int ADDR_W      = 16;
  localparam int CNT_W       = 4;

  localparam logic [ADDR_W-1:0] OFFSET_MASK = 16'hFFF0;

  // Counter values for "all words requested" and "last word returning".
  localparam logic [CNT_W-1:0] BLOCK_CNT = 4'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = 4'(BLOCK_WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // Byte address of word idx inside an aligned block. The block is aligned
  // and the offset is at most 14, so the sum never carries out of 16 bits.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [2:0]        idx);
    return base + {12'b0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Small synchronous up-counter used to track issued requests and accepted
// memory returns during a block fill.
module fill_counter
  import cache_fill_fsm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count register: reset and clear both return to zero; clear wins over inc.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache-side block fill FSM: accepts a miss, issues eight word reads to
// main memory, and writes each returned word (and finally the tag) into
// the cache arrays. Returns are counted, not timed, so any memory latency
// and any gaps between returns are tolerated.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [2:0]        fill_word,
  output logic              write_tag_array
);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  req_cnt;
  logic [CNT_W-1:0]  rsp_cnt;
  logic              in_fill;
  logic              start;

  // Reset forces every output low in the same cycle, even if the state
  // register still holds FILL until the edge.
  assign in_fill = (state == FILL) && !rst;
  assign start   = (state == IDLE) && miss_detected && !rst;

  fill_counter u_req_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .inc   (mem_read),
    .count (req_cnt)
  );

  fill_counter u_rsp_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .inc   (write_data_array),
    .count (rsp_cnt)
  );

  // State and block-base register: latch the aligned miss on entry, leave
  // FILL when the last word comes back. Misses seen during FILL are ignored.
  always_ff @(posedge clk) begin
    // NOTE: base is pure datapath and only observed in FILL, which is always
    // entered through the load below, so it is deliberately left unreset.
    if (rst) begin
      state <= IDLE;
    end else if (state == IDLE) begin
      if (miss_detected) begin
        state <= FILL;
        base  <= miss_address & OFFSET_MASK;
      end
    end else if (memory_data_valid && (rsp_cnt == LAST_WORD)) begin
      state <= IDLE;
    end
  end

  // Output decode from registered state and counters.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block
    // leaves a signal unassigned and infers a latch.
    fsm_busy         = 1'b0;
    mem_read         = 1'b0;
    memory_address   = miss_address & OFFSET_MASK;
    write_data_array = 1'b0;
    fill_word        = 3'd0;
    write_tag_array  = 1'b0;
    if (in_fill) begin
      fsm_busy         = 1'b1;
      mem_read         = (req_cnt < BLOCK_CNT);
      memory_address   = word_addr(base, req_cnt[2:0]);
      write_data_array = memory_data_valid;
      fill_word        = rsp_cnt[2:0];
      write_tag_array  = memory_data_valid && (rsp_cnt == LAST_WORD);
    end
  end

endmodule
